// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard bus: decode (master) presents the instruction, scoreboard (slave) answers
// with stall and per-operand forwarding selects.
interface hazard_scoreboard_if #(
  parameter int REG_AW     = 3,
  parameter int FWD_STAGES = 2
);
  localparam int FSW = $clog2(FWD_STAGES + 1);

  logic              issue_valid;
  logic [REG_AW-1:0] src1;
  logic [REG_AW-1:0] src2;
  logic              src1_used;
  logic              src2_used;
  logic [REG_AW-1:0] dst;
  logic              dst_wr;
  logic              is_load;
  logic              hold;
  logic              flush;
  logic              stall;
  logic [FSW-1:0]    fwd1_sel;
  logic [FSW-1:0]    fwd2_sel;

  modport master (
    output issue_valid, src1, src2, src1_used, src2_used, dst, dst_wr, is_load, hold, flush,
    input  stall, fwd1_sel, fwd2_sel
  );

  modport slave (
    input  issue_valid, src1, src2, src1_used, src2_used, dst, dst_wr, is_load, hold, flush,
    output stall, fwd1_sel, fwd2_sel
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard beside decode: forwarding-tap selection and load-use stall.
// Optional stall/forward statistics counters enabled by defining HAZARD_STATS_EN.
module hazard_scoreboard #(
  parameter int REG_AW     = 3,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 2,
  localparam int FSW       = $clog2(FWD_STAGES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        fwd_cnt
`endif
);

  logic [FWD_STAGES-1:0] entValid_q, entValid_d;
  logic [FWD_STAGES-1:0] entLoad_q, entLoad_d;
  logic [REG_AW-1:0]     entDst_q [FWD_STAGES];
  logic [REG_AW-1:0]     entDst_d [FWD_STAGES];
  logic [FWD_STAGES-1:0] entReady;

  logic [FSW-1:0] fwd1Sel, fwd2Sel;
  logic           pend1, pend2;
  logic           stall;

  // A load result becomes forwardable only once it has reached tap LOAD_LAT-1.
  always_comb begin
    entReady = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      entReady[k] = entValid_q[k] & (!entLoad_q[k] | (k >= LOAD_LAT - 1));
    end
  end

  // Scan oldest to youngest so the youngest match overwrites the selection.
  always_comb begin
    fwd1Sel = '0;
    fwd2Sel = '0;
    pend1   = 1'b0;
    pend2   = 1'b0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (bus.issue_valid && bus.src1_used && entValid_q[k] && (entDst_q[k] == bus.src1)) begin
        fwd1Sel = entReady[k] ? FSW'(k + 1) : '0;
        pend1   = !entReady[k];
      end
      if (bus.issue_valid && bus.src2_used && entValid_q[k] && (entDst_q[k] == bus.src2)) begin
        fwd2Sel = entReady[k] ? FSW'(k + 1) : '0;
        pend2   = !entReady[k];
      end
    end
  end

  assign stall        = bus.issue_valid & (pend1 | pend2) & !bus.flush;
  assign bus.stall    = stall;
  assign bus.fwd1_sel = fwd1Sel;
  assign bus.fwd2_sel = fwd2Sel;

  // Shift the in-flight window; a flush also kills the copy of old entry 0 landing in entry 1.
  always_comb begin
    entValid_d = entValid_q;
    entLoad_d  = entLoad_q;
    entDst_d   = entDst_q;
    if (!bus.hold) begin
      for (int k = FWD_STAGES - 1; k >= 1; k--) begin
        entValid_d[k] = entValid_q[k-1] & !(bus.flush && (k == 1));
        entLoad_d[k]  = entLoad_q[k-1];
        entDst_d[k]   = entDst_q[k-1];
      end
      entValid_d[0] = bus.issue_valid & bus.dst_wr & !stall & !bus.flush;
      entLoad_d[0]  = bus.is_load;
      entDst_d[0]   = bus.dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entValid_q <= '0;
      entLoad_q  <= '0;
      for (int k = 0; k < FWD_STAGES; k++) begin
        entDst_q[k] <= '0;
      end
    end else begin
      entValid_q <= entValid_d;
      entLoad_q  <= entLoad_d;
      for (int k = 0; k < FWD_STAGES; k++) begin
        entDst_q[k] <= entDst_d[k];
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stallCnt_q, stallCnt_d;
  logic [15:0] fwdCnt_q, fwdCnt_d;

  // Saturating event counters; frozen cycles are not counted.
  always_comb begin
    stallCnt_d = stallCnt_q;
    fwdCnt_d   = fwdCnt_q;
    if (!bus.hold) begin
      if (stall && (stallCnt_q != 16'hFFFF)) begin
        stallCnt_d = stallCnt_q + 16'd1;
      end
      if (((fwd1Sel != '0) || (fwd2Sel != '0)) && (fwdCnt_q != 16'hFFFF)) begin
        fwdCnt_d = fwdCnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt_q <= '0;
      fwdCnt_q   <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      fwdCnt_q   <= fwdCnt_d;
    end
  end

  assign stall_cnt = stallCnt_q;
  assign fwd_cnt   = fwdCnt_q;
`endif

endmodule
